// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial WIDTH-bit adder sequencer driving one full-adder
//               cell LSB-first, with registered carry feedback.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int            CW     = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;

  // The shared full-adder cell, fed from the LSBs of the operand shift regs
  assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c        = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_state <= c_RUN;
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_c;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_LAST) begin
            // r_carry here is the carry into the MSB
            r_state <= c_DONE;
            r_sum   <= w_res_next;
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == c_RUN);
  assign done     = (r_state == c_DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int total;
  int bad;
  logic [WIDTH-1:0] prev_sum;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views
  task automatic ref_add(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb, input logic rc,
                         output logic [WIDTH-1:0] es, output logic ec, output logic eo);
    int u;
    int s;
    u  = int'(ra) + int'(rb) + int'(rc);
    s  = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
    es = WIDTH'(u);
    ec = (u >= (1 << WIDTH));
    eo = (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
  endtask

  // Launches an add from the current (mid-cycle) point and checks the whole run.
  // inj >= 0 pulses start with inj_a during run cycle inj (must be ignored).
  task automatic op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic oc,
                    input int inj, input logic [WIDTH-1:0] inj_a, input string tag);
    logic [WIDTH-1:0] es;
    logic ec;
    logic eo;
    int nbusy;
    int ndone;
    logic stable;
    ref_add(oa, ob, oc, es, ec, eo);
    a = oa; b = ob; cin = oc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~oa; b = ~ob; cin = ~oc;
    nbusy = 0; ndone = 0; stable = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (sum !== prev_sum) stable = 1'b0;
      if (k == inj) begin
        start = 1'b1; a = inj_a;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(WIDTH));
    chk({tag, "_early_done"}, 32'(ndone), 32'd0);
    chk({tag, "_sum_stable"}, 32'(stable), 32'd1);
    chk({tag, "_done"}, {30'd0, busy, done}, 32'b01);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
    prev_sum = es;
  endtask

  initial begin
    int nd;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    total = 0; bad = 0; prev_sum = '0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("reset_outs", {27'd0, busy, done, cout, overflow, 1'b0}, 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    op(8'h0F, 8'h01, 1'b0, -1, '0, "t1");
    @(negedge clk);
    op(8'hFF, 8'h01, 1'b0, -1, '0, "t2a");
    @(negedge clk);
    op(8'h7F, 8'h00, 1'b1, -1, '0, "t2b");
    @(negedge clk);

    // Back-to-back: second launch happens while in DONE
    op(8'h80, 8'h80, 1'b1, -1, '0, "t3a");
    op(8'h01, 8'h02, 1'b0, -1, '0, "t3b");
    @(negedge clk);

    op(8'h11, 8'h22, 1'b0, 2, 8'hAA, "t4");
    @(posedge clk); #1;
    chk("t4_single_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a run
    a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst = 1'b1; #1;
    chk("t5_rst_flags", {29'd0, busy, done, cout}, 32'd0);
    chk("t5_rst_sum", {23'd0, overflow, sum}, 32'd0);
    prev_sum = '0;
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("t5_no_done", 32'(nd), 32'd0);
    @(negedge clk);
    op(8'h33, 8'h44, 1'b1, -1, '0, "t5_after");

    // Random operands, some launched back-to-back from DONE
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rb = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      op(ra, rb, rc, -1, '0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
